// File: rtl/target_mem_pkg.sv
// ----------------------------------------------------------------------------
// target_mem_pkg : shared states and constants for the byte memory target
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package target_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WR_DATA   = 3'd1,
      ST_WR_ACK    = 3'd2,
      ST_RD_WAIT   = 3'd3,
      ST_SPLIT_REQ = 3'd4,
      ST_RD_RESP   = 3'd5
   } tm_state_e;

   localparam logic RW_WRITE  = 1'b1;
   localparam logic RW_READ   = 1'b0;
   localparam int   CNT_WIDTH = 4;

endpackage

`default_nettype wire

// File: rtl/target_mem_ram.sv
// ----------------------------------------------------------------------------
// target_mem_ram : single-port byte RAM, synchronous write, registered read
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module target_mem_ram #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Array itself is never reset; only the read register is.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/target_mem_core.sv
// ----------------------------------------------------------------------------
// target_mem_core : byte memory target behind split_target_port, split reads
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module target_mem_core
   import target_mem_pkg::*;
#(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 8,
   parameter int READ_LATENCY = 4,
   parameter int SPLIT_EN     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           target_addr_in,
   input  logic                  target_addr_in_valid,
   input  logic [DATA_WIDTH-1:0] target_data_in,
   input  logic                  target_data_in_valid,
   input  logic                  target_rw,
   input  logic                  split_grant,
   output logic                  target_ready,
   output logic                  target_ack,
   output logic [DATA_WIDTH-1:0] target_data_out,
   output logic                  target_data_out_valid,
   output logic                  target_split_ack,
   output logic                  split_req,
   output logic                  err_overrun
);

   localparam logic [CNT_WIDTH-1:0] RD_LOAD = CNT_WIDTH'(READ_LATENCY - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam tm_state_e RESP_ST = (SPLIT_EN != 0) ? ST_SPLIT_REQ : ST_RD_RESP;

   tm_state_e             state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic [ADDR_WIDTH-1:0] addr_idx;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  ram_we, ram_re, accept;
   logic                  ready_q, ack_q, valid_q, split_ack_q, split_req_q, err_q;

   assign addr_idx = target_addr_in[ADDR_WIDTH-1:0];

   generate
      if (ADDR_WIDTH < 16) begin : g_addr_alias
         logic unused_addr_hi;
         assign unused_addr_hi = ^target_addr_in[15:ADDR_WIDTH];
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ram_we   = 1'b0;
      ram_re   = 1'b0;
      ram_addr = addr_idx;
      accept   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (target_addr_in_valid) begin
               accept = 1'b1;
               if (target_rw == RW_WRITE) begin
                  if (target_data_in_valid) begin
                     ram_we  = 1'b1;
                     state_d = ST_WR_ACK;
                  end else begin
                     state_d = ST_WR_DATA;
                  end
               end else begin
                  ram_re  = 1'b1;
                  cnt_d   = RD_LOAD;
                  // A one-cycle latency skips the wait state entirely.
                  state_d = (READ_LATENCY == 1) ? RESP_ST : ST_RD_WAIT;
               end
            end
         end
         ST_WR_DATA: begin
            ram_addr = idx_q;
            if (target_data_in_valid) begin
               ram_we  = 1'b1;
               state_d = ST_WR_ACK;
            end
         end
         ST_WR_ACK:  state_d = ST_IDLE;
         ST_RD_WAIT: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = RESP_ST;
            end
         end
         ST_SPLIT_REQ: begin
            if (split_grant) begin
               state_d = ST_RD_RESP;
            end
         end
         ST_RD_RESP: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         ready_q     <= 1'b1;
         ack_q       <= 1'b0;
         valid_q     <= 1'b0;
         split_ack_q <= 1'b0;
         split_req_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         if (accept) begin
            idx_q <= addr_idx;
         end
         ready_q     <= (state_q == ST_IDLE) && !accept;
         ack_q       <= (state_d == ST_WR_ACK);
         valid_q     <= (state_d == ST_RD_RESP);
         split_ack_q <= accept && (target_rw == RW_READ) && (SPLIT_EN != 0);
         split_req_q <= (state_d == ST_SPLIT_REQ);
         err_q       <= target_addr_in_valid && (state_q != ST_IDLE);
      end
   end

   target_mem_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (ram_addr),
      .wdata_i (target_data_in),
      .rdata_o (ram_rdata)
   );

   generate
      if (READ_LATENCY == 1 && SPLIT_EN == 0) begin : g_rd_direct
         assign target_data_out = ram_rdata;
      end else begin : g_rd_hold
         logic [DATA_WIDTH-1:0] dout_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               dout_q <= '0;
            end else if (state_d == ST_RD_RESP) begin
               dout_q <= ram_rdata;
            end
         end
         assign target_data_out = dout_q;
      end
   endgenerate

   assign target_ready          = ready_q;
   assign target_ack            = ack_q;
   assign target_data_out_valid = valid_q;
   assign target_split_ack      = split_ack_q;
   assign split_req             = split_req_q;
   assign err_overrun           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_target_mem_core.sv
// ----------------------------------------------------------------------------
// tb_target_mem_core : scoreboard bench, non-split and split instances in step
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_target_mem_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] addr = '0;
   logic        addr_v = 1'b0;
   logic [7:0]  wdata = '0;
   logic        data_v = 1'b0;
   logic        rw = 1'b0;
   logic        grant = 1'b0;

   logic       ns_ready, ns_ack, ns_dv, ns_sack, ns_sreq, ns_err;
   logic       sp_ready, sp_ack, sp_dv, sp_sack, sp_sreq, sp_err;
   logic [7:0] ns_dout, sp_dout;

   int nchecks = 0;
   int nerrs   = 0;

   logic [7:0] q_ns[$];
   logic [7:0] q_sp[$];
   logic [7:0] model [0:4095];
   logic [7:0] exp_ns, exp_sp;

   always #5 clk = ~clk;

   target_mem_core #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .READ_LATENCY(4), .SPLIT_EN(0)) dut_ns (
      .clk(clk), .rst(rst),
      .target_addr_in(addr), .target_addr_in_valid(addr_v),
      .target_data_in(wdata), .target_data_in_valid(data_v),
      .target_rw(rw), .split_grant(grant),
      .target_ready(ns_ready), .target_ack(ns_ack),
      .target_data_out(ns_dout), .target_data_out_valid(ns_dv),
      .target_split_ack(ns_sack), .split_req(ns_sreq), .err_overrun(ns_err)
   );

   target_mem_core #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .READ_LATENCY(4), .SPLIT_EN(1)) dut_sp (
      .clk(clk), .rst(rst),
      .target_addr_in(addr), .target_addr_in_valid(addr_v),
      .target_data_in(wdata), .target_data_in_valid(data_v),
      .target_rw(rw), .split_grant(grant),
      .target_ready(sp_ready), .target_ack(sp_ack),
      .target_data_out(sp_dout), .target_data_out_valid(sp_dv),
      .target_split_ack(sp_sack), .split_req(sp_sreq), .err_overrun(sp_err)
   );

   // Scoreboard consumers: every data-valid pulse pops one expected byte.
   always @(negedge clk) begin
      if (!rst && ns_dv) begin
         nchecks++;
         if (q_ns.size() == 0) begin
            nerrs++;
            $display("FAIL sb_ns: unexpected data 0x%02h with no read outstanding", ns_dout);
         end else begin
            exp_ns = q_ns.pop_front();
            if (ns_dout !== exp_ns) begin
               nerrs++;
               $display("FAIL sb_ns: data 0x%02h, expected 0x%02h", ns_dout, exp_ns);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && sp_dv) begin
         nchecks++;
         if (q_sp.size() == 0) begin
            nerrs++;
            $display("FAIL sb_sp: unexpected data 0x%02h with no read outstanding", sp_dout);
         end else begin
            exp_sp = q_sp.pop_front();
            if (sp_dout !== exp_sp) begin
               nerrs++;
               $display("FAIL sb_sp: data 0x%02h, expected 0x%02h", sp_dout, exp_sp);
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!(ns_ready && sp_ready) && n < 64) begin
         next_cycle();
         @(negedge clk);
         n++;
      end
      nchecks++;
      if (n >= 64) begin
         nerrs++;
         $display("FAIL wait_ready: timeout, ready ns=%b sp=%b, expected 1", ns_ready, sp_ready);
      end
      next_cycle();
   endtask

   task automatic test_reset();
      @(negedge clk);
      nchecks++;
      if ({ns_ready, ns_ack, ns_dv, ns_sack, ns_sreq, ns_err, ns_dout} !== {1'b1, 5'b0, 8'h00}) begin
         nerrs++;
         $display("FAIL reset_ns: outputs %b_%h, expected 100000_00",
                  {ns_ready, ns_ack, ns_dv, ns_sack, ns_sreq, ns_err}, ns_dout);
      end
      nchecks++;
      if ({sp_ready, sp_ack, sp_dv, sp_sack, sp_sreq, sp_err, sp_dout} !== {1'b1, 5'b0, 8'h00}) begin
         nerrs++;
         $display("FAIL reset_sp: outputs %b_%h, expected 100000_00",
                  {sp_ready, sp_ack, sp_dv, sp_sack, sp_sreq, sp_err}, sp_dout);
      end
      next_cycle();
      next_cycle();
      rst = 1'b0;
      next_cycle();
   endtask

   task automatic test_write();
      wait_ready();
      addr = 16'h800A; wdata = 8'h5C; rw = 1'b1; addr_v = 1'b1; data_v = 1'b1;
      model[12'h00A] = 8'h5C;
      for (int k = 1; k <= 3; k++) begin
         next_cycle();
         addr_v = 1'b0; data_v = 1'b0;
         @(negedge clk);
         nchecks++;
         if (ns_ack !== (k == 1) || sp_ack !== (k == 1)) begin
            nerrs++;
            $display("FAIL write_ack T+%0d: ns=%b sp=%b, expected %b", k, ns_ack, sp_ack, k == 1);
         end
         nchecks++;
         if (ns_ready !== (k == 3) || sp_ready !== (k == 3)) begin
            nerrs++;
            $display("FAIL write_ready T+%0d: ns=%b sp=%b, expected %b", k, ns_ready, sp_ready, k == 3);
         end
      end
      next_cycle();
   endtask

   task automatic test_split_write();
      wait_ready();
      addr = 16'h8010; rw = 1'b1; addr_v = 1'b1; data_v = 1'b0; wdata = 8'h33;
      model[12'h010] = 8'h33;
      for (int k = 1; k <= 5; k++) begin
         next_cycle();
         addr_v = 1'b0;
         data_v = (k == 3);
         @(negedge clk);
         nchecks++;
         if (ns_ack !== (k == 4) || sp_ack !== (k == 4)) begin
            nerrs++;
            $display("FAIL split_write_ack T+%0d: ns=%b sp=%b, expected %b", k, ns_ack, sp_ack, k == 4);
         end
      end
      data_v = 1'b0;
   endtask

   task automatic test_read_nonsplit();
      wait_ready();
      grant = 1'b1;
      addr = 16'h800A; rw = 1'b0; addr_v = 1'b1;
      q_ns.push_back(model[12'h00A]);
      q_sp.push_back(model[12'h00A]);
      for (int k = 1; k <= 6; k++) begin
         next_cycle();
         addr_v = 1'b0;
         @(negedge clk);
         nchecks++;
         if (ns_dv !== (k == 4) || ns_sack !== 1'b0 || ns_sreq !== 1'b0) begin
            nerrs++;
            $display("FAIL read_ns T+%0d: dv=%b sack=%b sreq=%b, expected dv=%b sack=0 sreq=0",
                     k, ns_dv, ns_sack, ns_sreq, k == 4);
         end
         nchecks++;
         if (sp_sack !== (k == 1) || sp_sreq !== (k == 4) || sp_dv !== (k == 5)) begin
            nerrs++;
            $display("FAIL read_sp_early_grant T+%0d: sack=%b sreq=%b dv=%b, expected %b %b %b",
                     k, sp_sack, sp_sreq, sp_dv, k == 1, k == 4, k == 5);
         end
         if (k == 4) begin
            nchecks++;
            if (ns_dout !== 8'h5C) begin
               nerrs++;
               $display("FAIL read_ns_data: 0x%02h, expected 0x5c", ns_dout);
            end
         end
      end
      grant = 1'b0;
   endtask

   task automatic test_read_split();
      wait_ready();
      grant = 1'b0;
      addr = 16'h800A; rw = 1'b0; addr_v = 1'b1;
      q_ns.push_back(model[12'h00A]);
      q_sp.push_back(model[12'h00A]);
      for (int k = 1; k <= 9; k++) begin
         next_cycle();
         addr_v = 1'b0;
         grant = (k == 7);
         @(negedge clk);
         nchecks++;
         if (sp_sack !== (k == 1) || sp_sreq !== (k >= 4 && k <= 7) || sp_dv !== (k == 8)) begin
            nerrs++;
            $display("FAIL read_split T+%0d: sack=%b sreq=%b dv=%b, expected %b %b %b",
                     k, sp_sack, sp_sreq, sp_dv, k == 1, k >= 4 && k <= 7, k == 8);
         end
         nchecks++;
         if (ns_dv !== (k == 4)) begin
            nerrs++;
            $display("FAIL read_split_ns T+%0d: dv=%b, expected %b", k, ns_dv, k == 4);
         end
      end
      grant = 1'b0;
   endtask

   task automatic test_readback(input logic [15:0] a);
      int n_ns = 0;
      int n_sp = 0;
      wait_ready();
      grant = 1'b1;
      addr = a; rw = 1'b0; addr_v = 1'b1;
      q_ns.push_back(model[a[11:0]]);
      q_sp.push_back(model[a[11:0]]);
      for (int k = 1; k <= 10; k++) begin
         next_cycle();
         addr_v = 1'b0;
         @(negedge clk);
         n_ns += int'(ns_dv);
         n_sp += int'(sp_dv);
      end
      nchecks++;
      if (n_ns != 1 || n_sp != 1) begin
         nerrs++;
         $display("FAIL readback_%h: pulses ns=%0d sp=%0d, expected 1", a, n_ns, n_sp);
      end
      grant = 1'b0;
   endtask

   task automatic test_alias_overrun();
      int n_ns = 0;
      int n_sp = 0;
      wait_ready();
      addr = 16'h0F44; wdata = 8'hA7; rw = 1'b1; addr_v = 1'b1; data_v = 1'b1;
      model[12'hF44] = 8'hA7;
      next_cycle();
      addr_v = 1'b0; data_v = 1'b0;
      wait_ready();
      grant = 1'b1;
      addr = 16'h8F44; rw = 1'b0; addr_v = 1'b1;
      q_ns.push_back(model[12'hF44]);
      q_sp.push_back(model[12'hF44]);
      for (int k = 1; k <= 8; k++) begin
         next_cycle();
         addr_v = (k == 2);
         addr = 16'h8010;
         @(negedge clk);
         nchecks++;
         if (ns_err !== (k == 3) || sp_err !== (k == 3)) begin
            nerrs++;
            $display("FAIL overrun T+%0d: ns=%b sp=%b, expected %b", k, ns_err, sp_err, k == 3);
         end
         n_ns += int'(ns_dv);
         n_sp += int'(sp_dv);
      end
      nchecks++;
      if (n_ns != 1 || n_sp != 1) begin
         nerrs++;
         $display("FAIL overrun_pulses: ns=%0d sp=%0d, expected 1", n_ns, n_sp);
      end
      grant = 1'b0;
   endtask

   task automatic test_data_only();
      wait_ready();
      wdata = 8'hFF; data_v = 1'b1;
      next_cycle();
      data_v = 1'b0;
      @(negedge clk);
      nchecks++;
      if ({ns_ack, ns_err, ns_ready, sp_ack, sp_err, sp_ready} !== 6'b001_001) begin
         nerrs++;
         $display("FAIL data_only: ack/err/ready ns=%b%b%b sp=%b%b%b, expected 001 001",
                  ns_ack, ns_err, ns_ready, sp_ack, sp_err, sp_ready);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid_read();
      wait_ready();
      grant = 1'b0;
      addr = 16'h800A; rw = 1'b0; addr_v = 1'b1;
      next_cycle();
      addr_v = 1'b0;
      next_cycle();
      rst = 1'b1;
      #1;
      nchecks++;
      if ({ns_ready, ns_ack, ns_dv, ns_sack, ns_sreq, ns_err, ns_dout,
           sp_ready, sp_ack, sp_dv, sp_sack, sp_sreq, sp_err, sp_dout} !==
          {1'b1, 5'b0, 8'h00, 1'b1, 5'b0, 8'h00}) begin
         nerrs++;
         $display("FAIL reset_mid_read: ns=%b_%h sp=%b_%h, expected 100000_00 both",
                  {ns_ready, ns_ack, ns_dv, ns_sack, ns_sreq, ns_err}, ns_dout,
                  {sp_ready, sp_ack, sp_dv, sp_sack, sp_sreq, sp_err}, sp_dout);
      end
      next_cycle();
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         next_cycle();
         @(negedge clk);
         nchecks++;
         if ({ns_dv, sp_dv, ns_sreq, sp_sreq} !== 4'b0000) begin
            nerrs++;
            $display("FAIL after_reset cycle %0d: dv ns=%b sp=%b sreq ns=%b sp=%b, expected 0",
                     k, ns_dv, sp_dv, ns_sreq, sp_sreq);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_split_write();
      test_read_nonsplit();
      test_read_split();
      test_readback(16'h8010);
      test_alias_overrun();
      test_data_only();
      test_reset_mid_read();
      test_readback(16'h800A);
      wait_ready();
      nchecks++;
      if (q_ns.size() != 0 || q_sp.size() != 0) begin
         nerrs++;
         $display("FAIL scoreboard_drain: left ns=%0d sp=%0d, expected 0", q_ns.size(), q_sp.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/target_mem_core.md
Name: target_mem_core

Overview:
Byte-wide memory target core that sits directly behind split_target_port on the target side. It consumes the deserialised address, data and rw strobes, performs the write or read, and returns read data, ack and split handshakes to the port. It also provides the split-transaction behaviour for slow reads, and is the backing store for slave 3 (0x8000–0x8FFF).

Parameters:
ADDR_WIDTH, 12, number of low address bits used; depth is 2**ADDR_WIDTH bytes, and upper address bits are ignored (aliasing).
DATA_WIDTH, 8, data byte width.
READ_LATENCY, 4, cycles from read acceptance to response availability; legal range 1..15.
SPLIT_EN, 1, 1 = reads use the split handshake; 0 = reads answer while holding the bus.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
target_addr_in  in  16  address from split_target_port
target_addr_in_valid  in  1  address strobe, 1-cycle pulse
target_data_in  in  8  write data from port
target_data_in_valid  in  1  write data strobe, 1-cycle pulse
target_rw  in  1  1 = write, 0 = read; sampled with the address strobe
split_grant  in  1  port/arbiter grant for split resume
target_ready  out  1  high when able to accept a command
target_ack  out  1  1-cycle pulse on write completion
target_data_out  out  8  read data
target_data_out_valid  out  1  1-cycle read-data strobe
target_split_ack  out  1  1-cycle pulse: read split, bus released
split_req  out  1  request to resume a split read
err_overrun  out  1  1-cycle pulse: strobe arrived while busy, dropped

Behaviour:
- Reset (async, rst=1): state IDLE, target_ready=1, all other outputs 0, counter 0. Memory contents are not reset. Any pending operation is discarded and no response is emitted after reset.
- All outputs are registered.
- States: IDLE, WR_DATA, WR_ACK, RD_WAIT, SPLIT_REQ, RD_RESP.
- Address strobe accepted only in IDLE. Idx = target_addr_in[ADDR_WIDTH-1:0].
- IDLE, addr_valid & rw=1 & data_valid in the same cycle T: RAM written at edge T, then WR_ACK. target_ack=1 during T+1, back to IDLE at T+2.
- IDLE, addr_valid & rw=1 without data_valid: latch idx and go to WR_DATA. Wait there indefinitely for data_valid, then write and go to WR_ACK.
- IDLE, addr_valid & rw=0 at T: RAM read at T (registered), counter loaded with READ_LATENCY-1, go to RD_WAIT. If SPLIT_EN, target_split_ack=1 during T+1 only.
- RD_WAIT decrements the counter each cycle. At 0:
  - SPLIT_EN=0: go to RD_RESP, so target_data_out_valid=1 exactly during cycle T+READ_LATENCY.
  - SPLIT_EN=1: go to SPLIT_REQ; split_req=1 from cycle T+READ_LATENCY.
- SPLIT_REQ: hold split_req until split_grant is sampled high at edge G. Then split_req=0 and target_data_out_valid=1 during G+1. A grant already high at entry gives data at T+READ_LATENCY+1.
- RD_RESP lasts one cycle; target_data_out holds the byte until the next response; return to IDLE.
- target_ready=1 only in IDLE; it drops in the cycle after acceptance.
- Address strobe while not IDLE: command dropped, err_overrun pulses next cycle, state unchanged.
- data_valid without addr_valid in IDLE: ignored, no error.
- split_grant outside SPLIT_REQ: ignored.

Decomposition:
- Package target_mem_pkg holds:
  - state enum tm_state_e;
  - constants RW_WRITE=1'b1 and RW_READ=1'b0;
  - localparam for the counter width (4 bits).
- Sub-module target_mem_ram: single-port, synchronous-write, registered-read byte RAM parameterised by ADDR_WIDTH/DATA_WIDTH.
- FSM, counter and handshakes live in target_mem_core.

Test Plan:
- Write: addr 0x800A, data 0x5C, rw=1 in one cycle T -> target_ack high only at T+1; target_ready low T+1..T+2, high again at T+3.
- Split-address write: addr 0x8010 rw=1 at T, data 0x33 at T+3 -> target_ack at T+4. A later read of 0x8010 returns 0x33.
- Non-split read (SPLIT_EN=0, READ_LATENCY=4): read 0x800A at T -> target_data_out=0x5C, valid only at T+4; target_split_ack and split_req never assert.
- Split read (SPLIT_EN=1): read 0x800A at T, split_grant raised 3 cycles after split_req -> split_ack at T+1, split_req from T+4 to grant, data 0x5C valid the cycle after grant.
- Aliasing/overrun: write 0xA7 to 0x0F44, read 0x8F44 -> 0xA7. A second addr strobe during RD_WAIT -> err_overrun pulse, and exactly one data-valid pulse.
- Reset mid-read: rst asserted in RD_WAIT -> outputs 0, target_ready=1 immediately; no data_valid or split_req follows.
